// File: rtl/imm_narrow_pkg.sv
// Shared types and constants for the immediate-narrowing block.
// The width defaults normally come from the shared def.v; fallbacks keep a standalone build whole.
`ifndef PC_mem_Addr_n
`define PC_mem_Addr_n 16
`endif
`ifndef Imm_n
`define Imm_n 8
`endif

package imm_narrow_pkg;

  // How the low IMM_W bits are meant to be re-extended by the consumer.
  typedef enum logic {
    FIELD_UNSIGNED = 1'b0,
    FIELD_SIGNED   = 1'b1
  } field_e;

  localparam int              CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/imm_narrow_skid.sv
// narrow_skid: two-entry elastic buffer (output register + skid register).
// in_ready comes straight from a flop, so upstream never sees a combinational path from out_ready.
module narrow_skid #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         in_fire;

  assign in_fire  = in_valid && in_ready;
  assign in_ready = !skid_valid;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the payload registers are reset too, because out_data must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || out_ready) begin
      // Output slot frees this edge: refill from skid first to keep order.
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_fire;
        if (in_fire) out_data <= in_data;
      end
    end else if (in_fire) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/imm_narrow.sv
// imm_narrow: narrows a WORD_W word to an IMM_W immediate, flags overflow and counts it.
// Define IMM_NARROW_SAT_EN to saturate overflowing values; by default they wrap.
module imm_narrow
  import imm_narrow_pkg::*;
#(
  parameter int WORD_W = `PC_mem_Addr_n,
  parameter int IMM_W  = `Imm_n
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_flag,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IMM_W-1:0]  out_data,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  ovf_cnt,
  input  logic              clr_cnt
);

  field_e                    field;
  logic [WORD_W-IMM_W-1:0]   upper_u;
  logic [WORD_W-IMM_W:0]     upper_s;
  logic                      fit;
  logic [IMM_W-1:0]          narrowed;
  logic                      in_fire;

  assign field   = field_e'(in_flag);
  assign upper_u = in_data[WORD_W-1:IMM_W];
  assign upper_s = in_data[WORD_W-1:IMM_W-1];
  assign in_fire = in_valid && in_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    fit      = 1'b0;
    narrowed = in_data[IMM_W-1:0];
    if (field == FIELD_SIGNED) fit = (&upper_s) || !(|upper_s);
    else                       fit = !(|upper_u);
`ifdef IMM_NARROW_SAT_EN
    if (!fit) begin
      if (field == FIELD_UNSIGNED)  narrowed = '1;
      else if (in_data[WORD_W-1])   narrowed = {1'b1, {(IMM_W-1){1'b0}}};
      else                          narrowed = {1'b0, {(IMM_W-1){1'b1}}};
    end
`endif
  end

  narrow_skid #(
    .W(IMM_W + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({!fit, narrowed}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data ({out_ovf, out_data})
  );

  // Clear wins over a same-edge increment; the count sticks at its maximum.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt)                               ovf_cnt <= '0;
    else if (in_fire && !fit && ovf_cnt != CNT_MAX)   ovf_cnt <= ovf_cnt + 1'b1;
  end

endmodule

// File: tb/tb_imm_narrow.sv
// Self-checking bench for imm_narrow (WORD_W=16, IMM_W=8): directed corner cases plus
// randomized traffic against a queue-based reference model.
module tb_imm_narrow;

  localparam int WORD_W = 16;
  localparam int IMM_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_flag;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [IMM_W-1:0]  out_data;
  logic              out_ovf;
  logic [7:0]        ovf_cnt;
  logic              clr_cnt;

  imm_narrow #(
    .WORD_W(WORD_W),
    .IMM_W (IMM_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_flag  (in_flag),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .ovf_cnt  (ovf_cnt),
    .clr_cnt  (clr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  int   cnt_m;
  int   checks;
  int   failures;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: range test on the numeric value, then wrap or saturate.
  function automatic exp_t model(input logic flag, input logic [15:0] d);
    exp_t e;
    int   v;
    bit   fit;
    v = 0;
    if (!flag) fit = (d < 16'd256);
    else begin
      v   = $signed(d);
      fit = (v >= -128) && (v <= 127);
    end
    e.ovf  = !fit;
    e.data = d[7:0];
`ifdef IMM_NARROW_SAT_EN
    if (!fit) begin
      if (!flag)      e.data = 8'hFF;
      else if (v < 0) e.data = 8'h80;
      else            e.data = 8'h7F;
    end
`endif
    return e;
  endfunction

  task automatic check_state();
    check("out_valid", out_valid, q.size() > 0);
    check("in_ready", in_ready, q.size() < 2);
    check("ovf_cnt", ovf_cnt, cnt_m);
    if (q.size() > 0) begin
      check("out_data", out_data, q[0].data);
      check("out_ovf", out_ovf, q[0].ovf);
    end
  endtask

  task automatic next();
    @(negedge clk);
    check_state();
  endtask

  task automatic drive(input logic v, input logic flag, input logic [15:0] d,
                       input logic ordy, input logic clr);
    bit   in_fire;
    bit   out_fire;
    exp_t e;
    in_valid  = v;
    in_flag   = flag;
    in_data   = d;
    out_ready = ordy;
    clr_cnt   = clr;
    e        = model(flag, d);
    in_fire  = v && (q.size() < 2);
    out_fire = ordy && (q.size() > 0);
    if (out_fire) void'(q.pop_front());
    if (in_fire) q.push_back(e);
    if (clr) cnt_m = 0;
    else if (in_fire && e.ovf && cnt_m < 255) cnt_m++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      next();
    end
  endtask

  function automatic logic [15:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom);
      1:       return 16'($urandom_range(0, 16'h01FF));
      2:       return 16'($urandom_range(16'hFF00, 16'hFFFF));
      default: return 16'($urandom_range(16'h0060, 16'h00A0));
    endcase
  endfunction

  initial begin
    checks    = 0;
    failures  = 0;
    cnt_m     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_flag   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clr_cnt   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    next();
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_ovf", out_ovf, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);

    // Signed field that fits.
    drive(1'b1, 1'b1, 16'hFFF0, 1'b1, 1'b0);
    next();
    check("fit_s_valid", out_valid, 1'b1);
    check("fit_s_data", out_data, 8'hF0);
    check("fit_s_ovf", out_ovf, 1'b0);
    check("fit_s_cnt", ovf_cnt, 8'd0);
    idle(1);

    // Unsigned overflow.
    drive(1'b1, 1'b0, 16'h0123, 1'b1, 1'b0);
    next();
    check("ovf_u_ovf", out_ovf, 1'b1);
    check("ovf_u_cnt", ovf_cnt, 8'd1);
`ifdef IMM_NARROW_SAT_EN
    check("ovf_u_data", out_data, 8'hFF);
`else
    check("ovf_u_data", out_data, 8'h23);
`endif

    // Signed overflow, positive then negative, back to back.
    drive(1'b1, 1'b1, 16'h0080, 1'b1, 1'b0);
    next();
    check("ovf_sp_ovf", out_ovf, 1'b1);
`ifdef IMM_NARROW_SAT_EN
    check("ovf_sp_data", out_data, 8'h7F);
`else
    check("ovf_sp_data", out_data, 8'h80);
`endif
    drive(1'b1, 1'b1, 16'hFF7F, 1'b1, 1'b0);
    next();
    check("ovf_sn_ovf", out_ovf, 1'b1);
`ifdef IMM_NARROW_SAT_EN
    check("ovf_sn_data", out_data, 8'h80);
`else
    check("ovf_sn_data", out_data, 8'h7F);
`endif
    idle(1);

    // Backpressure: two accepted, third held off, then drained in order.
    drive(1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
    next();
    drive(1'b1, 1'b0, 16'h0002, 1'b0, 1'b0);
    next();
    drive(1'b1, 1'b0, 16'h0003, 1'b0, 1'b0);
    next();
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_head", out_data, 8'h01);
    drive(1'b1, 1'b0, 16'h0003, 1'b1, 1'b0);
    next();
    check("bp_second", out_data, 8'h02);
    drive(1'b1, 1'b0, 16'h0003, 1'b1, 1'b0);
    next();
    check("bp_third", out_data, 8'h03);
    idle(1);
    check("bp_drained", out_valid, 1'b0);

    // Counter saturation, then clear on an overflowing transfer edge.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b0, 16'h0100 | 16'($urandom_range(0, 16'hFEFF)), 1'b1, 1'b0);
      next();
    end
    check("cnt_sat", ovf_cnt, 8'd255);
    drive(1'b1, 1'b0, 16'h0200, 1'b1, 1'b1);
    next();
    check("cnt_clr", ovf_cnt, 8'd0);
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), rand_word(),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
      next();
    end
    idle(2);

    // Reset with both entries full and a nonzero count.
    drive(1'b1, 1'b0, 16'h0211, 1'b0, 1'b0);
    next();
    drive(1'b1, 1'b1, 16'hFF80, 1'b0, 1'b0);
    next();
    check("full_in_ready", in_ready, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    cnt_m = 0;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_ready", in_ready, 1'b1);
    check("mid_rst_cnt", ovf_cnt, 8'd0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_narrow.md
IMM_NARROW -- requirements
Module: imm_narrow

Interface
REQ-001 Parameter WORD_W, default `PC_mem_Addr_n, width of the full-width input word.
REQ-002 Parameter IMM_W, default `Imm_n, width of the narrowed immediate; IMM_W < WORD_W SHALL hold.
REQ-003 Clocking SHALL be one clock, clk; reset SHALL be rst, synchronous and active-high.
REQ-004 Ports SHALL be:
  clk  input  1  rising-edge clock
  rst  input  1  synchronous active-high reset
  in_valid  input  1  producer offers a word
  in_ready  output  1  block accepts a word (registered)
  in_flag  input  1  0 = unsigned field, 1 = signed field
  in_data  input  WORD_W  full-width value to narrow
  out_valid  output  1  narrowed result available
  out_ready  input  1  consumer accepts result
  out_data  output  IMM_W  narrowed immediate
  out_ovf  output  1  value did not fit in IMM_W
  ovf_cnt  output  8  saturating count of accepted overflowing words
  clr_cnt  input  1  clear ovf_cnt

Function
REQ-005 A transfer SHALL occur on an input edge with in_valid&&in_ready, and on an output edge with out_valid&&out_ready.
REQ-006 Fit check, unsigned: in_data[WORD_W-1:IMM_W] all zero; signed: in_data[WORD_W-1:IMM_W-1] all equal; out_ovf = !fit.
REQ-007 For fitting values, out_data SHALL be in_data[IMM_W-1:0]; zero/sign-extending out_data per in_flag SHALL reproduce in_data exactly.
REQ-008 Overflow handling SHALL be per the Configuration section.
REQ-009 Latency SHALL be 1 cycle: a word accepted at edge N with an empty buffer SHALL appear with out_valid=1 after edge N.
REQ-010 Buffering SHALL be 2 entries (output register + skid register); full throughput of 1 word/cycle while out_ready=1.
REQ-011 in_ready SHALL be 0 exactly when both entries are occupied; a word offered while in_ready=0 SHALL NOT be accepted.
REQ-012 Order SHALL be preserved; no word lost or duplicated under any in_valid/out_ready pattern.
REQ-013 Simultaneous input and output transfer with both entries full SHALL NOT occur (in_ready=0); with one entry full, occupancy SHALL stay 1.
REQ-014 out_data/out_ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-015 ovf_cnt SHALL increment on each input transfer with out_ovf=1 and saturate at 255 (no wrap).
REQ-016 clr_cnt=1 SHALL set ovf_cnt to 0 next edge, taking priority over a same-edge increment.

Reset
REQ-017 On rst: out_valid=0, out_data=0, out_ovf=0, ovf_cnt=0, both entries emptied; in_ready=1 after the reset edge.
REQ-018 Reset mid-operation SHALL discard buffered words; no partial result emitted afterwards.

Configuration
REQ-019 Macro IMM_NARROW_SAT_EN: defined -> overflowing values saturate (unsigned: all ones; signed positive: 0 followed by ones; signed negative: 1 followed by zeros).
REQ-020 Without IMM_NARROW_SAT_EN: overflowing values wrap (out_data = in_data[IMM_W-1:0]); out_ovf and ovf_cnt identical in both builds.

Structure
REQ-021 WORD_W/IMM_W defaults SHALL come from the shared def.v defines (`PC_mem_Addr_n, `Imm_n); no local width constants.
REQ-022 The 2-entry buffer SHALL be sub-module narrow_skid, parameterised on payload width IMM_W+1; fit/saturate logic stays in imm_narrow.

Verification (WORD_W=16, IMM_W=8)
REQ-023 flag=1, in_data=0xFFF0 -> next cycle out_data=0xF0, out_ovf=0, ovf_cnt=0.
REQ-024 flag=0, 0x0123 -> out_ovf=1, ovf_cnt=1; out_data=0x23 without SAT_EN, 0xFF with it.
REQ-025 flag=1, 0x0080 then 0xFF7F -> both out_ovf=1; SAT_EN build 0x7F then 0x80, else 0x80 then 0x7F.
REQ-026 out_ready=0 for 3 cycles while offering 0x0001,0x0002,0x0003 -> two accepted, in_ready=0, then outputs 0x01,0x02,0x03 in order after out_ready=1.
REQ-027 300 overflowing transfers -> ovf_cnt=255; clr_cnt=1 on an overflowing transfer edge -> ovf_cnt=0.
REQ-028 rst asserted with both entries full -> after the edge out_valid=0, in_ready=1, ovf_cnt=0, no stale output later.
